// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode values and FSM state encoding.
package alu_pkg;

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_INC  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_OR   = 3'd6;
  localparam logic [2:0] OP_XOR  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier core: loads on start, runs N steps, pulses done
// with the full 2N-bit product held in the accumulator.
module mul_seq #(
  parameter  int N  = 12,
  localparam int CW = $clog2(N) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] product
);

  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start) begin
      mcand_d  = {{N{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      // Always run all N steps so latency is independent of operand values.
      if (cnt_q == CW'(N - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready on both sides; single-cycle ops resolve on accept,
// MUL is handed to mul_seq and the result is captured when it signals done.
//
// state   | meaning
// ST_IDLE | waiting for an operation, in_ready=1
// ST_MUL  | multiplier iterating, in_ready=0
// ST_DONE | result/flags valid and held until out_ready
module alu_seq
  import alu_pkg::*;
#(
  parameter int N = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   alu_op,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] alu_out,
  output logic         z,
  output logic         c
);

  state_e         state_q, state_d;
  logic [N-1:0]   res_q, res_d;
  logic           z_q, z_d;
  logic           c_q, c_d;

  logic           accept;
  logic           mul_start;
  logic           mul_done;
  logic [2*N-1:0] mul_prod;

  logic [N:0]     add_sum;
  logic [N:0]     sub_diff;
  logic [N:0]     inc_sum;
  logic [N-1:0]   op_res;
  logic           op_c;

  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign mul_start = accept & (alu_op == OP_MUL);

  mul_seq #(.N(N)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (in1),
    .b       (in2),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Single-cycle datapath; the top bit of sub_diff is the borrow (in1 < in2).
  always_comb begin
    add_sum  = {1'b0, in1} + {1'b0, in2};
    sub_diff = {1'b0, in1} - {1'b0, in2};
    inc_sum  = {1'b0, in1} + (N+1)'(1);
    op_res   = in1;
    op_c     = 1'b0;
    case (alu_op)
      OP_PASS: op_res = in1;
      OP_ADD:  begin op_res = add_sum[N-1:0];  op_c = add_sum[N];  end
      OP_SUB:  begin op_res = sub_diff[N-1:0]; op_c = sub_diff[N]; end
      OP_INC:  begin op_res = inc_sum[N-1:0];  op_c = inc_sum[N];  end
      OP_AND:  op_res = in1 & in2;
      OP_OR:   op_res = in1 | in2;
      OP_XOR:  op_res = in1 ^ in2;
      default: op_res = in1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    z_d     = z_q;
    c_d     = c_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (alu_op == OP_MUL) begin
            state_d = ST_MUL;
          end else begin
            state_d = ST_DONE;
            res_d   = op_res;
            c_d     = op_c;
            z_d     = (op_res == '0);
          end
        end else if ((state_q == ST_DONE) && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d = ST_DONE;
          res_d   = mul_prod[N-1:0];
          c_d     = |mul_prod[2*N-1:N];
          z_d     = (mul_prod[N-1:0] == '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign alu_out   = res_q;
  assign z         = z_q;
  assign c         = c_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: expected results are queued on accept and compared
// when the consumer takes them; latency, backpressure and reset are checked inline.
module tb_alu_seq;
  localparam int N = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_op;
  logic [N-1:0] in1;
  logic [N-1:0] in2;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] alu_out;
  logic         z;
  logic         c;

  int checks = 0;
  int errors = 0;
  int takes  = 0;
  logic [N+1:0] sb_q[$];

  always #5 clk = ~clk;

  alu_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .z         (z),
    .c         (c)
  );

  function automatic logic [N+1:0] model(input logic [2:0] op, input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    logic [2*N-1:0] p;
    logic [N:0]     s;
    logic [N-1:0]   r;
    logic           cf;
    cf = 1'b0;
    r  = a;
    case (op)
      3'd0: r = a;
      3'd1: begin s = {1'b0, a} + {1'b0, b}; r = s[N-1:0]; cf = s[N]; end
      3'd2: begin r = a - b; cf = (a < b); end
      3'd3: begin
        p  = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        r  = p[N-1:0];
        cf = (p[2*N-1:N] != '0);
      end
      3'd4: begin s = {1'b0, a} + 1; r = s[N-1:0]; cf = s[N]; end
      3'd5: r = a & b;
      3'd6: r = a | b;
      default: r = a ^ b;
    endcase
    return {r, (r == '0), cf};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples the handshakes just before the edge, then advances one clock.
  task automatic tick();
    logic [N+1:0] e;
    #1;
    if (out_valid && out_ready) begin
      chk("sb_nonempty", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_res", 32'(alu_out), 32'(e[N+1:2]));
        chk("sb_z", 32'(z), 32'(e[1]));
        chk("sb_c", 32'(c), 32'(e[0]));
      end
      takes++;
    end
    if (in_valid && in_ready) sb_q.push_back(model(alu_op, in1, in2));
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    int k;
    in_valid = 1'b1;
    alu_op   = op;
    in1      = a;
    in2      = b;
    #1;
    k = 0;
    while (!in_ready && k < 40) begin
      tick();
      k++;
    end
    chk("issue_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    in1      = N'($urandom);
    in2      = N'($urandom);
    alu_op   = 3'($urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  logic [N-1:0] mul_a[5] = '{12'd30, 12'd100, 12'd0, 12'd4095, 12'd77};
  logic [N-1:0] mul_b[5] = '{12'd10, 12'd100, 12'd1234, 12'd4095, 12'd0};

  initial begin
    int lat;
    int t0;
    logic seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 3'd0; in1 = '0; in2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_alu_out", 32'(alu_out), 0);
    chk("rst_z", 32'(z), 0);
    chk("rst_c", 32'(c), 0);
    @(negedge clk);
    rst = 1'b0;

    issue(3'd1, 12'd5, 12'd10);
    chk("add_lat", 32'(out_valid), 1);
    chk("add_res", 32'(alu_out), 15);
    chk("add_zc", {30'd0, z, c}, 0);
    tick();
    chk("add_taken", 32'(out_valid), 0);

    issue(3'd2, 12'd5, 12'd10);
    chk("sub_res", 32'(alu_out), 4091);
    chk("sub_c", 32'(c), 1);
    issue(3'd1, 12'd4095, 12'd1);
    chk("wrap_res", 32'(alu_out), 0);
    chk("wrap_zc", {30'd0, z, c}, 3);
    tick();

    for (int i = 0; i < 5; i++) begin
      issue(3'd3, mul_a[i], mul_b[i]);
      chk("mul_busy_ready", 32'(in_ready), 0);
      wait_out(lat);
      chk("mul_latency", 32'(lat), 13);
      if (i == 0) begin
        chk("mul_30x10", 32'(alu_out), 300);
        chk("mul_30x10_c", 32'(c), 0);
      end
      if (i == 1) begin
        chk("mul_100x100", 32'(alu_out), 1808);
        chk("mul_100x100_c", 32'(c), 1);
      end
      tick();
    end

    out_ready = 1'b0;
    issue(3'd7, 12'hF0F, 12'h0FF);
    in_valid = 1'b1; alu_op = 3'd1; in1 = 12'd1; in2 = 12'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_res", 32'(alu_out), 32'h0FF0);
      chk("bp_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_new_valid", 32'(out_valid), 1);
    chk("bp_new_res", 32'(alu_out), 3);
    tick();

    t0 = takes;
    in_valid = 1'b1;
    alu_op = 3'd1; in1 = 12'd100;  in2 = 12'd23;  tick();
    chk("b2b_v1", 32'(out_valid), 1);
    alu_op = 3'd4; in1 = 12'd4095; in2 = 12'd0;   tick();
    chk("b2b_v2", 32'(out_valid), 1);
    alu_op = 3'd5; in1 = 12'hABC;  in2 = 12'h0F0; tick();
    chk("b2b_v3", 32'(out_valid), 1);
    in_valid = 1'b0;
    tick();
    chk("b2b_takes", 32'(takes - t0), 3);

    issue(3'd3, 12'd4, 12'd20);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_out", {19'd0, alu_out, z, c}, 0);
    chk("abort_ready", 32'(in_ready), 1);
    sb_q.delete();
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen = seen | out_valid;
    end
    chk("abort_no_valid", 32'(seen), 0);
    issue(3'd1, 12'd4, 12'd20);
    chk("post_rst_add", 32'(alu_out), 24);
    tick();

    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
